// File: rtl/attention_tile_feeder.sv
// attention_tile_feeder
//
// Buffers K_TILE-long tiles of (q, k, v) triples in two ping-pong banks.
// Each buffered tile is replayed into the attention core. While one bank
// streams out, the other bank can load.
//
// Sequence per tile: a one-cycle core_start pulse, then K_TILE triples over
// a valid/ready handshake. The block then snoops the core's result
// handshake before it starts the next tile.
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   soft_clr                    synchronous clear with the same effect as reset
//   ld_valid/ld_ready/ld_data   load stream, ld_data = {q, k, v}
//   core_start                  one-cycle start pulse to the core
//   core_valid/core_ready       triple handshake to the core
//   core_q/core_k/core_v        current triple
//   res_valid/res_ready         snooped result handshake of the core
//   tile_done                   one-cycle pulse after a result handshake
//   tiles_done                  completed-tile count (wraps at 16 bits)
//   busy                        FSM not idle, or a bank holds a full tile
module attention_tile_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int K_TILE     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_clr,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [3*DATA_WIDTH-1:0] ld_data,
  output logic                    core_start,
  output logic                    core_valid,
  input  logic                    core_ready,
  output logic [DATA_WIDTH-1:0]   core_q,
  output logic [DATA_WIDTH-1:0]   core_k,
  output logic [DATA_WIDTH-1:0]   core_v,
  input  logic                    res_valid,
  input  logic                    res_ready,
  output logic                    tile_done,
  output logic [15:0]             tiles_done,
  output logic                    busy
);
  localparam int EW = 3 * DATA_WIDTH;
  localparam int PW = $clog2(K_TILE);
  localparam logic [PW-1:0] LAST = PW'(K_TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      full_reg, full_next;
  logic            wr_bank_reg, wr_bank_next;
  logic            rd_bank_reg, rd_bank_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            tile_done_reg, tile_done_next;
  logic [15:0]     tiles_done_reg, tiles_done_next;
  logic            ld_fire;
  logic [1:0][EW-1:0] rd_word;
  logic [EW-1:0]   cur_word;

  assign ld_ready = !full_reg[wr_bank_reg];
  assign ld_fire  = ld_valid && ld_ready;

  // One storage array per bank. A bank is only ever written while it is
  // not full, so the reader never sees its tile change under it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [EW-1:0] mem [K_TILE];

      always_ff @(posedge clk) begin
        if (ld_fire && (wr_bank_reg == 1'(gi))) begin
          mem[wr_ptr_reg] <= ld_data;
        end
      end

      assign rd_word[gi] = mem[rd_ptr_reg];
    end
  endgenerate

  assign cur_word = rd_word[rd_bank_reg];
  assign core_q   = cur_word[EW-1 -: DATA_WIDTH];
  assign core_k   = cur_word[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign core_v   = cur_word[DATA_WIDTH-1:0];

  assign tile_done  = tile_done_reg;
  assign tiles_done = tiles_done_reg;
  assign busy       = (state_reg != S_IDLE) || (|full_reg);

  always_comb begin
    state_next      = state_reg;
    full_next       = full_reg;
    wr_bank_next    = wr_bank_reg;
    rd_bank_next    = rd_bank_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    tile_done_next  = 1'b0;
    tiles_done_next = tiles_done_reg;
    core_start      = 1'b0;
    core_valid      = 1'b0;

    // Load side. The writer only touches a non-full bank and the reader only
    // a full one, so a fill and a drain in the same cycle hit different bits.
    if (ld_fire) begin
      if (wr_ptr_reg == LAST) begin
        full_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = ~wr_bank_reg;
        wr_ptr_next            = '0;
      end else begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (full_reg[rd_bank_reg]) state_next = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_next = S_STREAM;
      end
      S_STREAM: begin
        core_valid = 1'b1;
        if (core_ready) begin
          if (rd_ptr_reg == LAST) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = ~rd_bank_reg;
            rd_ptr_next            = '0;
            state_next             = S_WAIT;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Holding here until the core hands back its result means the core
        // is idle again before the next start pulse.
        if (res_valid && res_ready) begin
          tile_done_next  = 1'b1;
          tiles_done_next = tiles_done_reg + 16'd1;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      full_reg       <= '0;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      tile_done_reg  <= 1'b0;
      tiles_done_reg <= '0;
    end else if (soft_clr) begin
      state_reg      <= S_IDLE;
      full_reg       <= '0;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      tile_done_reg  <= 1'b0;
      tiles_done_reg <= '0;
    end else begin
      state_reg      <= state_next;
      full_reg       <= full_next;
      wr_bank_reg    <= wr_bank_next;
      rd_bank_reg    <= rd_bank_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      tile_done_reg  <= tile_done_next;
      tiles_done_reg <= tiles_done_next;
    end
  end

endmodule

// File: tb/tb_attention_tile_feeder.sv
// Bench for attention_tile_feeder. The reference model tracks tiles as
// queues of triples, a count of buffered tiles and the in-flight tile. It
// predicts the DUT outputs on every cycle, and a few literal checks pin the
// model down.
module tb_attention_tile_feeder;
  localparam int W = 16;
  localparam int K = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           soft_clr = 1'b0;
  logic           ld_valid = 1'b0;
  logic [3*W-1:0] ld_data = '0;
  logic           core_ready = 1'b0;
  logic           res_valid = 1'b0;
  logic           res_ready = 1'b0;
  logic           ld_ready, core_start, core_valid, tile_done, busy;
  logic [W-1:0]   core_q, core_k, core_v;
  logic [15:0]    tiles_done;

  always #5 clk = ~clk;

  attention_tile_feeder #(.DATA_WIDTH(W), .K_TILE(K)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .core_start(core_start), .core_valid(core_valid), .core_ready(core_ready),
    .core_q(core_q), .core_k(core_k), .core_v(core_v),
    .res_valid(res_valid), .res_ready(res_ready),
    .tile_done(tile_done), .tiles_done(tiles_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3*W-1:0] exp_q[$];   // triples of complete tiles, in emission order
  logic [3*W-1:0] part_q[$];  // partially loaded tile
  logic [3*W-1:0] obs_q[$];   // triples observed at core handshakes
  int          m_held = 0;    // complete tiles buffered and not fully streamed
  bit          m_active = 0;  // a tile has started and its result is pending
  int          m_rem = 0;     // triples still to stream for the active tile
  bit          m_start = 0;
  bit          m_done = 0;
  logic [15:0] m_tiles = '0;
  int cyc = 0, last_ld_cyc = -100, rfire_cyc = -100;
  int start_count = 0, lat_ld_start = 0, lat_res_start = 0;
  bit preset_req = 0, preset_done = 0;

  always @(negedge clk) begin
    bit ev, ldf, cf, rf, nd, ns;
    int nh;
    cyc++;
    if (preset_req && !preset_done) begin
      m_tiles = 16'hFFFE;
      preset_done = 1;
    end
    if (!rst_n) begin
      exp_q.delete(); part_q.delete();
      m_held = 0; m_active = 0; m_rem = 0; m_start = 0; m_done = 0; m_tiles = '0;
    end
    ev = m_active && !m_start && (m_rem > 0);
    chk("ld_ready", ld_ready, m_held < 2);
    chk("core_start", core_start, m_start);
    chk("core_valid", core_valid, ev);
    chk("tile_done", tile_done, m_done);
    chk("tiles_done", tiles_done, m_tiles);
    chk("busy", busy, m_active || (m_held > 0));
    if (ev && core_valid && exp_q.size() > 0)
      chk("triple", {core_q, core_k, core_v}, exp_q[0]);
    if (core_start === 1'b1) begin
      start_count++;
      lat_ld_start  = cyc - last_ld_cyc;
      lat_res_start = cyc - rfire_cyc;
    end
    if (!rst_n || soft_clr) begin
      exp_q.delete(); part_q.delete();
      m_held = 0; m_active = 0; m_rem = 0; m_start = 0; m_done = 0; m_tiles = '0;
    end else begin
      ldf = ld_valid && (m_held < 2);
      cf  = ev && core_ready;
      rf  = res_valid && res_ready;
      nd  = m_active && !m_start && (m_rem == 0) && rf;
      ns  = !m_active && (m_held > 0);
      nh  = m_held;
      if (ldf) begin
        part_q.push_back(ld_data);
        last_ld_cyc = cyc;
        if (part_q.size() == K) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          nh++;
        end
      end
      if (cf) begin
        obs_q.push_back({core_q, core_k, core_v});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_rem--;
        if (m_rem == 0) nh--;
      end
      if (nd) begin
        m_active = 0;
        m_tiles  = m_tiles + 16'd1;
        rfire_cyc = cyc;
      end
      if (ns) begin
        m_active = 1;
        m_rem = K;
      end
      m_start = ns;
      m_done  = nd;
      m_held  = nh;
    end
  end

  // ---------------- core model ----------------
  int core_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
  int res_delay = 4;
  bit res_rnd = 0;

  initial begin
    int cnt = 0, dly = 0, pat = 0;
    bit pend = 0, f, rf, clr;
    forever begin
      @(negedge clk);
      f = core_valid && core_ready;
      rf = res_valid && res_ready;
      clr = soft_clr || !rst_n;
      @(posedge clk);
      #1;
      if (clr) begin
        cnt = 0; pend = 0; res_valid = 0;
      end else begin
        if (f) begin
          cnt++;
          if (cnt == K) begin cnt = 0; pend = 1; dly = res_delay; end
        end
        if (rf) res_valid = 0;
        if (pend) begin
          if (dly == 0) begin res_valid = 1; pend = 0; end
          else dly--;
        end
      end
      res_ready = res_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      case (core_mode)
        0: core_ready = 1'b1;
        1: begin core_ready = (pat == 0); pat = (pat + 1) % 3; end
        default: core_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [3*W-1:0] d, input int gap);
    int t = 0;
    if (gap > 0) begin
      ld_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    ld_valid = 1;
    ld_data = d;
    while (!ld_ready && t < 2000) begin @(posedge clk); #1; t++; end
    if (!ld_ready) begin
      checks++; errors++;
      $display("FAIL ld_timeout actual=stalled required=accept at %0t", $time);
    end
    @(posedge clk); #1;
    ld_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (busy && t < 5000);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
    end
  endtask

  task automatic pulse_clr();
    soft_clr = 1; @(posedge clk); #1; soft_clr = 0;
  endtask

  function automatic logic [3*W-1:0] trip(input int a, input int b, input int c);
    return {16'(a), 16'(b), 16'(c)};
  endfunction

  initial begin
    int base, sc0, t;
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sc0, t;
    logic [3*W-1:0] sent[$];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tiles_done", tiles_done, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // single tile, triple i = {i, 2i, 3i}
    base = obs_q.size(); sc0 = start_count;
    for (int i = 0; i < K; i++) send_beat(trip(i, 2*i, 3*i), 0);
    wait_idle();
    chk("t1_ld_to_start", lat_ld_start, 2);
    chk("t1_starts", start_count - sc0, 1);
    chk("t1_count", obs_q.size() - base, K);
    chk("t1_beat5", obs_q[base+5], trip(5, 10, 15));
    chk("t1_beat15", obs_q[base+15], trip(15, 30, 45));
    chk("t1_tiles_done", tiles_done, 1);
    $display("single tile done");

    // ping-pong: three tiles back-to-back
    pulse_clr();
    base = obs_q.size(); sent.delete();
    for (int i = 0; i < 3*K; i++) begin
      logic [3*W-1:0] d;
      d = {16'($urandom), 16'($urandom), 16'($urandom)};
      sent.push_back(d);
      ld_valid = 1;
      send_beat(d, 0);
    end
    wait_idle();
    chk("pp_tiles_done", tiles_done, 3);
    chk("pp_count", obs_q.size() - base, 3*K);
    chk("pp_first", obs_q[base], sent[0]);
    chk("pp_last", obs_q[base+3*K-1], sent[3*K-1]);
    $display("ping-pong done");

    // backpressure 1,0,0
    pulse_clr();
    core_mode = 1; base = obs_q.size();
    for (int i = 0; i < K; i++) send_beat(trip(100+i, 200+i, 300+i), 0);
    wait_idle();
    chk("bp_count", obs_q.size() - base, K);
    chk("bp_beat7", obs_q[base+7], trip(107, 207, 307));
    $display("backpressure done");

    // result gating: result withheld 20 cycles while second bank is full
    pulse_clr();
    core_mode = 0; res_delay = 20; sc0 = start_count;
    for (int i = 0; i < 2*K; i++) send_beat(trip(i, i+1, i+2), 0);
    wait_idle();
    chk("gate_starts", start_count - sc0, 2);
    chk("gate_res_to_start", lat_res_start, 2);
    chk("gate_tiles_done", tiles_done, 2);
    $display("result gating done");

    // soft_clr at stream beat 7 with the other bank half-loaded
    pulse_clr();
    res_delay = 4; base = obs_q.size();
    for (int i = 0; i < K; i++) send_beat(trip(50+i, 60+i, 70+i), 0);
    for (int i = 0; i < K/2; i++) send_beat(trip(1, 2, 3), 0);
    t = 0;
    while (obs_q.size() - base < 7 && t < 500) begin @(posedge clk); #1; t++; end
    chk("clr_reached_beat7", obs_q.size() - base, 7);
    pulse_clr();
    chk("clr_core_valid", core_valid, 0);
    chk("clr_ld_ready", ld_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_tiles_done", tiles_done, 0);
    base = obs_q.size();
    for (int i = 0; i < K; i++) send_beat(trip(16'hC000+i, 16'hD000+i, 16'hE000+i), 0);
    wait_idle();
    chk("clr_fresh_beat0", obs_q[base], trip(16'hC000, 16'hD000, 16'hE000));
    chk("clr_fresh_count", obs_q.size() - base, K);
    chk("clr_fresh_tiles", tiles_done, 1);
    $display("soft clear done");

    // count wrap: preset the counter near the top, then run two tiles
    pulse_clr();
    dut.tiles_done_reg = 16'hFFFE;
    preset_req = 1;
    for (int i = 0; i < K; i++) send_beat(trip(i, i, i), 0);
    wait_idle();
    chk("wrap_ffff", tiles_done, 16'hFFFF);
    for (int i = 0; i < K; i++) send_beat(trip(i, i, i), 0);
    wait_idle();
    chk("wrap_zero", tiles_done, 16'h0000);
    $display("wrap done");

    // random traffic
    pulse_clr();
    core_mode = 2; res_rnd = 1; res_delay = 3;
    for (int i = 0; i < 4*K; i++)
      send_beat({16'($urandom), 16'($urandom), 16'($urandom)}, int'($urandom_range(0, 2)));
    wait_idle();
    chk("rnd_tiles_done", tiles_done, 4);
    $display("random done");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
